// File: rtl/capdriver_bbm_if.sv
// Handshake and drive bus between SAR logic and the capacitor-array driver stage.
// master = SAR side (requests), slave = driver stage (levels, enables, status).
interface capdriver_bbm_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] dac_state;
    logic             dac_state_valid;
    logic             dac_drive_invert;
    logic [WIDTH-1:0] dac_drive_mask;
    logic             dac_reset_req;
    logic [WIDTH-1:0] dac_drive;
    logic [WIDTH-1:0] dac_drive_en;
    logic             dac_busy;
    logic             dac_done;

    modport master (
        output dac_state, dac_state_valid, dac_drive_invert, dac_drive_mask, dac_reset_req,
        input  dac_drive, dac_drive_en, dac_busy, dac_done
    );

    modport slave (
        input  dac_state, dac_state_valid, dac_drive_invert, dac_drive_mask, dac_reset_req,
        output dac_drive, dac_drive_en, dac_busy, dac_done
    );
endinterface

// File: rtl/capdriver_bbm.sv
// Break-before-make capacitor-array driver: registered, masked-inversion levels; changing bits high-Z for DEAD_CYCLES.
// Latency 1 cycle (no change) or 1+DEAD_CYCLES; requests arriving during BREAK are dropped, wait for dac_done.
module capdriver_bbm #(
    parameter int   WIDTH       = 16,
    parameter int   DEAD_CYCLES = 1,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    capdriver_bbm_if.slave bus
);
    typedef enum logic {IDLE, BREAK} state_t;

    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] drive_q, drive_nx;
    logic [WIDTH-1:0] en_q, en_nx;
    logic [WIDTH-1:0] target_q, target_nx;
    logic [WIDTH-1:0] target_in, diff;
    logic             busy_q, busy_nx;
    logic             done_q, done_nx;
    logic [3:0]       cnt_q, cnt_nx;
    logic             req;

    // Reset request overrides the data path so the array can be precharged from any code.
    always_comb begin
        target_in = bus.dac_state ^ ({WIDTH{bus.dac_drive_invert}} & bus.dac_drive_mask);
        if (bus.dac_reset_req)
            target_in = {WIDTH{RESET_LEVEL}};
        diff = target_in ^ drive_q;
        req  = bus.dac_state_valid | bus.dac_reset_req;
    end

    always_comb begin
        state_nx  = state;
        drive_nx  = drive_q;
        en_nx     = en_q;
        target_nx = target_q;
        busy_nx   = busy_q;
        done_nx   = 1'b0;
        cnt_nx    = cnt_q;
        case (state)
            IDLE: begin
                if (req) begin
                    if (diff == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx  = BREAK;
                        en_nx     = ~diff;
                        target_nx = target_in;
                        busy_nx   = 1'b1;
                        cnt_nx    = DEAD_LOAD;
                    end
                end
            end
            BREAK: begin
                if (cnt_q == 4'd0) begin
                    state_nx = IDLE;
                    drive_nx = target_q;
                    en_nx    = '1;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            drive_q  <= {WIDTH{RESET_LEVEL}};
            en_q     <= '1;
            target_q <= {WIDTH{RESET_LEVEL}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= 4'd0;
        end else begin
            state    <= state_nx;
            drive_q  <= drive_nx;
            en_q     <= en_nx;
            target_q <= target_nx;
            busy_q   <= busy_nx;
            done_q   <= done_nx;
            cnt_q    <= cnt_nx;
        end
    end

    assign bus.dac_drive    = drive_q;
    assign bus.dac_drive_en = en_q;
    assign bus.dac_busy     = busy_q;
    assign bus.dac_done     = done_q;
endmodule

// File: tb/tb_capdriver_bbm.sv
// Directed bench for capdriver_bbm with WIDTH=16, DEAD_CYCLES=2, RESET_LEVEL=0.
module tb_capdriver_bbm;
    localparam int DEAD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    capdriver_bbm_if #(.WIDTH(16)) bus ();

    capdriver_bbm #(
        .WIDTH(16),
        .DEAD_CYCLES(DEAD),
        .RESET_LEVEL(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        rreq;
        logic [15:0] st;
        logic        inv;
        logic [15:0] mask;
        logic        brk;
        logic [15:0] en_brk;
        logic [15:0] fin;
    } vec_t;

    vec_t        vecs [7];
    logic [15:0] model_drive;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Called at a negedge; leaves the bench at the negedge of the done cycle.
    task automatic run_vec(input int idx, input vec_t v);
        bus.dac_state_valid  = v.vld;
        bus.dac_reset_req    = v.rreq;
        bus.dac_state        = v.st;
        bus.dac_drive_invert = v.inv;
        bus.dac_drive_mask   = v.mask;
        @(negedge clk);
        bus.dac_state_valid  = 1'b0;
        bus.dac_reset_req    = 1'b0;
        bus.dac_state        = 16'hDEAD;
        bus.dac_drive_invert = ~v.inv;
        bus.dac_drive_mask   = 16'hFFFF;
        if (v.brk) begin
            for (int k = 0; k < DEAD; k++) begin
                check($sformatf("v%0d brk%0d en", idx, k), bus.dac_drive_en, v.en_brk);
                check($sformatf("v%0d brk%0d drive", idx, k), bus.dac_drive, model_drive);
                check($sformatf("v%0d brk%0d busy", idx, k), 16'(bus.dac_busy), 16'd1);
                check($sformatf("v%0d brk%0d done", idx, k), 16'(bus.dac_done), 16'd0);
                @(negedge clk);
            end
        end
        check($sformatf("v%0d drive", idx), bus.dac_drive, v.fin);
        check($sformatf("v%0d en", idx), bus.dac_drive_en, 16'hFFFF);
        check($sformatf("v%0d busy", idx), 16'(bus.dac_busy), 16'd0);
        check($sformatf("v%0d done", idx), 16'(bus.dac_done), 16'd1);
        model_drive = v.fin;
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;

        //         vld   rreq  state     inv   mask      brk   en_brk    final
        vecs[0] = '{1'b1, 1'b0, 16'h00F0, 1'b0, 16'h0000, 1'b1, 16'hFF0F, 16'h00F0};
        vecs[1] = '{1'b1, 1'b0, 16'h00F0, 1'b1, 16'h000F, 1'b1, 16'hFFF0, 16'h00FF};
        vecs[2] = '{1'b1, 1'b0, 16'h00FF, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 16'h00FF};
        vecs[3] = '{1'b1, 1'b0, 16'h00FF, 1'b1, 16'hFF00, 1'b1, 16'h00FF, 16'hFFFF};
        vecs[4] = '{1'b1, 1'b0, 16'hAAAA, 1'b0, 16'h0000, 1'b1, 16'hAAAA, 16'hAAAA};
        vecs[5] = '{1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1, 16'h5555, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, 16'h5A5A, 1'b1, 16'hFFFF, 1'b0, 16'hFFFF, 16'h0000};

        bus.dac_state_valid  = 1'b0;
        bus.dac_reset_req    = 1'b0;
        bus.dac_state        = 16'h0000;
        bus.dac_drive_invert = 1'b0;
        bus.dac_drive_mask   = 16'h0000;
        model_drive          = 16'h0000;

        repeat (2) @(negedge clk);
        check("rst drive", bus.dac_drive, 16'h0000);
        check("rst en", bus.dac_drive_en, 16'hFFFF);
        check("rst busy", 16'(bus.dac_busy), 16'd0);
        check("rst done", 16'(bus.dac_done), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle done", 16'(bus.dac_done), 16'd0);

        // Each vector starts in the done cycle of the previous one (back-to-back acceptance).
        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Request during BREAK is dropped; exactly one done pulse for the accepted one.
        done_cnt = 0;
        busy_cnt = 0;
        bus.dac_state_valid = 1'b1;
        bus.dac_state       = 16'h00F0;
        bus.dac_drive_invert = 1'b0;
        @(negedge clk);
        bus.dac_state = 16'h1234;
        busy_cnt += int'(bus.dac_busy);
        @(negedge clk);
        bus.dac_state_valid = 1'b0;
        busy_cnt += int'(bus.dac_busy);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            done_cnt += int'(bus.dac_done);
            busy_cnt += int'(bus.dac_busy);
        end
        check("ign drive", bus.dac_drive, 16'h00F0);
        check("ign done count", 16'(done_cnt), 16'd1);
        check("ign busy cycles", 16'(busy_cnt), 16'(DEAD));
        model_drive = 16'h00F0;

        // Asynchronous reset in the middle of BREAK discards the pending target.
        bus.dac_state_valid = 1'b1;
        bus.dac_state       = 16'hFFFF;
        @(negedge clk);
        bus.dac_state_valid = 1'b0;
        check("mid en", bus.dac_drive_en, 16'h00F0);
        #2 rst = 1'b1;
        #1;
        check("arst drive", bus.dac_drive, 16'h0000);
        check("arst en", bus.dac_drive_en, 16'hFFFF);
        check("arst busy", 16'(bus.dac_busy), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            done_cnt += int'(bus.dac_done);
        end
        check("arst no done", 16'(done_cnt), 16'd0);
        check("arst drive hold", bus.dac_drive, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end
endmodule
